// File: rtl/mac_pe_dbw.sv
// Weight-stationary systolic MAC processing element with double-buffered weights.
// Optional macro MAC_PE_SAT_EN selects a saturating accumulate instead of wrap-around.
module mac_pe_dbw #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [SUM_W-1:0]  in_sum,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic signed [SUM_W-1:0]  out_sum,
  input  logic                     w_load,
  input  logic signed [DATA_W-1:0] w_in,
  output logic                     w_load_out,
  output logic signed [DATA_W-1:0] w_out,
  input  logic                     w_swap,
  output logic                     w_swap_out,
  input  logic                     ovf_clr,
  output logic                     ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  // Signed overflow: both operands share a sign and the result's sign differs.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic signed [SUM_W-1:0] limit_sum(
    input logic signed [SUM_W-1:0] raw,
    input logic                    ovf_hit,
    input logic                    neg_ops
  );
`ifdef MAC_PE_SAT_EN
    if (ovf_hit) return neg_ops ? SUM_MIN : SUM_MAX;
    return raw;
`else
    logic unused;
    unused = ovf_hit ^ neg_ops;
    return raw;
`endif
  endfunction

  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q,  out_data_d;
  logic signed [SUM_W-1:0]  out_sum_q,   out_sum_d;
  logic                     w_load_out_q;
  logic signed [DATA_W-1:0] w_out_q;
  logic                     w_swap_out_q;
  logic                     ovf_q,       ovf_d;
  logic signed [DATA_W-1:0] shadow_q,    shadow_d;
  logic signed [DATA_W-1:0] active_q,    active_d;

  logic signed [PROD_W-1:0] prod_p0;
  logic signed [SUM_W-1:0]  prod_ext_p0;
  logic signed [SUM_W-1:0]  sum_raw_p0;
  logic                     sum_ovf_p0;

  always_comb begin
    prod_p0     = PROD_W'(in_data) * PROD_W'(active_q);
    prod_ext_p0 = SUM_W'(prod_p0);
    sum_raw_p0  = in_sum + prod_ext_p0;
    sum_ovf_p0  = add_ovf(in_sum[SUM_W-1], prod_ext_p0[SUM_W-1], sum_raw_p0[SUM_W-1]);

    out_valid_d = in_valid;
    out_data_d  = out_data_q;
    out_sum_d   = out_sum_q;
    if (in_valid) begin
      out_data_d = in_data;
      out_sum_d  = limit_sum(sum_raw_p0, sum_ovf_p0, in_sum[SUM_W-1]);
    end

    // A fresh overflow outranks a clear arriving in the same cycle.
    ovf_d = ovf_q;
    if (in_valid && sum_ovf_p0) ovf_d = 1'b1;
    else if (ovf_clr)           ovf_d = 1'b0;

    // Swap reads the shadow before a concurrent load overwrites it.
    active_d = w_swap ? shadow_q : active_q;
    shadow_d = w_load ? w_in     : shadow_q;
  end

  // ---- stage p0 -> p1 register boundary ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sum_q    <= '0;
      w_load_out_q <= 1'b0;
      w_out_q      <= '0;
      w_swap_out_q <= 1'b0;
      ovf_q        <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sum_q    <= out_sum_d;
      w_load_out_q <= w_load;
      w_out_q      <= w_in;
      w_swap_out_q <= w_swap;
      ovf_q        <= ovf_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sum    = out_sum_q;
  assign w_load_out = w_load_out_q;
  assign w_out      = w_out_q;
  assign w_swap_out = w_swap_out_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_mac_pe_dbw.sv
// Bench for mac_pe_dbw: directed scenarios plus randomized traffic against an
// arithmetic reference model; honours MAC_PE_SAT_EN the same way as the design.
module tb_mac_pe_dbw;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 24;
  localparam longint SMAX = (longint'(1) << (SUM_W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (SUM_W - 1));

  logic                     clk;
  logic                     reset_n;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic signed [SUM_W-1:0]  in_sum;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic signed [SUM_W-1:0]  out_sum;
  logic                     w_load;
  logic signed [DATA_W-1:0] w_in;
  logic                     w_load_out;
  logic signed [DATA_W-1:0] w_out;
  logic                     w_swap;
  logic                     w_swap_out;
  logic                     ovf_clr;
  logic                     ovf;

  int n_chk  = 0;
  int n_pass = 0;

  longint m_active, m_shadow, m_sum, m_data, m_wout;
  bit     m_valid, m_ovf, m_wl, m_ws;

  mac_pe_dbw #(.DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_sum(in_sum),
    .out_valid(out_valid), .out_data(out_data), .out_sum(out_sum),
    .w_load(w_load), .w_in(w_in), .w_load_out(w_load_out), .w_out(w_out),
    .w_swap(w_swap), .w_swap_out(w_swap_out),
    .ovf_clr(ovf_clr), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reduce an exact integer result to what a SUM_W accumulator should hold.
  function automatic longint fit_sum(input longint t);
    longint m;
`ifdef MAC_PE_SAT_EN
    if (t > SMAX) return SMAX;
    if (t < SMIN) return SMIN;
    return t;
`else
    m = t % (longint'(1) << SUM_W);
    if (m < 0) m += (longint'(1) << SUM_W);
    if (m > SMAX) m -= (longint'(1) << SUM_W);
    return m;
`endif
  endfunction

  task automatic model_reset();
    m_active = 0; m_shadow = 0; m_sum = 0; m_data = 0; m_wout = 0;
    m_valid = 0; m_ovf = 0; m_wl = 0; m_ws = 0;
  endtask

  task automatic idle();
    in_valid = 0; in_data = '0; in_sum = '0;
    w_load = 0; w_in = '0; w_swap = 0; ovf_clr = 0;
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".out_valid"},  longint'(out_valid),  longint'(m_valid));
    chk({pfx, ".out_data"},   longint'(out_data),   m_data);
    chk({pfx, ".out_sum"},    longint'(out_sum),    m_sum);
    chk({pfx, ".w_out"},      longint'(w_out),      m_wout);
    chk({pfx, ".w_load_out"}, longint'(w_load_out), longint'(m_wl));
    chk({pfx, ".w_swap_out"}, longint'(w_swap_out), longint'(m_ws));
    chk({pfx, ".ovf"},        longint'(ovf),        longint'(m_ovf));
  endtask

  // Apply current inputs for one clock edge and check against the model.
  task automatic tick(input string pfx);
    longint t;
    bit     o;
    o = 0;
    if (in_valid) begin
      t = longint'(in_sum) + longint'(in_data) * m_active;
      o = (t > SMAX) || (t < SMIN);
      m_sum  = fit_sum(t);
      m_data = longint'(in_data);
    end
    m_valid = in_valid;
    if (in_valid && o) m_ovf = 1;
    else if (ovf_clr)  m_ovf = 0;
    m_wout = longint'(w_in);
    m_wl   = w_load;
    m_ws   = w_swap;
    if (w_swap) m_active = m_shadow;
    if (w_load) m_shadow = longint'(w_in);
    @(posedge clk);
    #1;
    check_all(pfx);
  endtask

  task automatic load_active(input logic signed [DATA_W-1:0] w);
    idle(); w_load = 1; w_in = w; tick("ld");
    idle(); w_swap = 1;            tick("sw");
    idle();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    reset_n = 1'b1;

    // Build up state, then assert reset asynchronously mid-cycle.
    load_active(8'sd3);
    in_valid = 1; in_data = 8'sd5; in_sum = 24'sd1; tick("pre");
    chk("pre.sum", longint'(out_sum), 16);
    w_load = 1; w_in = 8'sd6; in_data = 8'sd2; tick("pre2");
    in_valid = 1; in_data = 8'sd9; w_swap = 1;
    #3 reset_n = 1'b0;
    #1;
    chk("arst.out_valid",  longint'(out_valid),  0);
    chk("arst.out_data",   longint'(out_data),   0);
    chk("arst.out_sum",    longint'(out_sum),    0);
    chk("arst.w_out",      longint'(w_out),      0);
    chk("arst.w_load_out", longint'(w_load_out), 0);
    chk("arst.w_swap_out", longint'(w_swap_out), 0);
    chk("arst.ovf",        longint'(ovf),        0);
    model_reset();
    #2 reset_n = 1'b1;
    idle(); w_swap = 1; tick("post_swap");
    idle(); in_valid = 1; in_data = 8'sd3; in_sum = 24'sd7; tick("post");
    chk("post.sum", longint'(out_sum), 7);

    // Load, swap, basic MAC.
    idle(); w_load = 1; w_in = 8'sd5; tick("c0");
    chk("c0.w_out", longint'(w_out), 5);
    chk("c0.w_load_out", longint'(w_load_out), 1);
    idle(); w_swap = 1; tick("c1");
    chk("c1.w_swap_out", longint'(w_swap_out), 1);
    idle(); in_valid = 1; in_data = -8'sd4; in_sum = 24'sd100; tick("c2");
    chk("c2.sum", longint'(out_sum), 80);
    chk("c2.data", longint'(out_data), -4);
    chk("c2.valid", longint'(out_valid), 1);

    // Swap during compute: active 5, shadow 2.
    idle(); w_load = 1; w_in = 8'sd2; tick("sd0");
    idle(); w_swap = 1; in_valid = 1; in_data = 8'sd10; in_sum = '0; tick("sd1");
    chk("sd1.sum", longint'(out_sum), 50);
    w_swap = 0; tick("sd2");
    chk("sd2.sum", longint'(out_sum), 20);

    // Simultaneous load and swap with shadow 2.
    idle(); w_load = 1; w_in = 8'sd9; w_swap = 1; tick("ls0");
    idle(); in_valid = 1; in_data = 8'sd1; tick("ls1");
    chk("ls1.sum", longint'(out_sum), 2);
    w_swap = 1; tick("ls2");
    chk("ls2.sum", longint'(out_sum), 2);
    w_swap = 0; tick("ls3");
    chk("ls3.sum", longint'(out_sum), 9);

    // Overflow, stickiness, clear.
    load_active(8'sd5);
    in_valid = 1; in_sum = 24'sd8388600; in_data = 8'sd10; tick("ov0");
`ifdef MAC_PE_SAT_EN
    chk("ov0.sum", longint'(out_sum), 8388607);
`else
    chk("ov0.sum", longint'(out_sum), -8388566);
`endif
    chk("ov0.ovf", longint'(ovf), 1);
    in_sum = '0; in_data = 8'sd1; tick("ov1");
    chk("ov1.sticky", longint'(ovf), 1);
    ovf_clr = 1; in_sum = 24'sd8388600; in_data = 8'sd10; tick("ov2");
    chk("ov2.clr_vs_new", longint'(ovf), 1);
    in_sum = '0; in_data = 8'sd1; tick("ov3");
    chk("ov3.cleared", longint'(ovf), 0);
    ovf_clr = 0; in_sum = -24'sd8388600; in_data = -8'sd10; tick("ov4");
`ifdef MAC_PE_SAT_EN
    chk("ov4.sum", longint'(out_sum), -8388608);
`else
    chk("ov4.sum", longint'(out_sum), 8388566);
`endif
    chk("ov4.ovf", longint'(ovf), 1);

    // Bubble handling with active 4.
    load_active(8'sd4);
    ovf_clr = 1; tick("bclr");
    idle(); in_valid = 1; in_data = 8'sd2; tick("b0");
    chk("b0.sum", longint'(out_sum), 8);
    in_valid = 0; in_data = 8'sd7; tick("b1");
    chk("b1.valid", longint'(out_valid), 0);
    chk("b1.sum_held", longint'(out_sum), 8);
    chk("b1.data_held", longint'(out_data), 2);
    in_valid = 1; in_data = 8'sd3; tick("b2");
    chk("b2.sum", longint'(out_sum), 12);

    // Randomized traffic, biased toward the accumulator extremes.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DATA_W'($urandom);
      w_in     = DATA_W'($urandom);
      w_load   = ($urandom_range(0, 3) == 0);
      w_swap   = ($urandom_range(0, 4) == 0);
      ovf_clr  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       in_sum = SUM_W'(SMAX - longint'($urandom_range(0, 20000)));
        1:       in_sum = SUM_W'(SMIN + longint'($urandom_range(0, 20000)));
        default: in_sum = SUM_W'($urandom);
      endcase
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
